// File: rtl/r_mul_multicycle_if.sv
// Operand/result handshake bundle for r_mul_multicycle.
// slave = multiplier side, master = producer/consumer side.
interface r_mul_multicycle_if #(
    parameter int N_BITS = 32
);
    logic              valid_i;
    logic              ready_o;
    logic [N_BITS-1:0] a_i;
    logic [N_BITS-1:0] b_i;
    logic              signed_i;
    logic              valid_o;
    logic              ready_i;
    logic [N_BITS-1:0] res_lo_o;
    logic [N_BITS-1:0] res_hi_o;

    modport slave (
        input  valid_i, a_i, b_i, signed_i, ready_i,
        output ready_o, valid_o, res_lo_o, res_hi_o
    );

    modport master (
        output valid_i, a_i, b_i, signed_i, ready_i,
        input  ready_o, valid_o, res_lo_o, res_hi_o
    );
endinterface

// File: rtl/r_mul_multicycle.sv
// Multicycle radix-N_RADIX shift-add multiplier, MSB-first digit recurrence.
// Optional macro MUL_SIGNED_EN enables signed operation via signed_i.
//
// state | meaning
// IDLE  | ready_o=1, waiting for operands
// BUSY  | one multiplier digit consumed per cycle
// DONE  | valid_o=1, result held until ready_i
module r_mul_multicycle #(
    parameter int N_BITS  = 32,
    parameter int N_RADIX = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    r_mul_multicycle_if.slave bus
);
    localparam int K     = $clog2(N_RADIX);
    localparam int STEPS = N_BITS / K;
    localparam int CW    = $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic                ready_q;
    logic                valid_q;
    logic [N_BITS-1:0]   a_q;
    logic [N_BITS-1:0]   b_q;
    logic [2*N_BITS-1:0] acc_q;
    logic [CW-1:0]       cnt_q;

    logic [K-1:0]        digit;
    logic [2*N_BITS-1:0] partial;
    logic [2*N_BITS-1:0] acc_d;

`ifdef MUL_SIGNED_EN
    logic sign_q;
`else
    logic unused_signed;
    assign unused_signed = bus.signed_i;
`endif

    always_comb begin
        digit   = b_q[N_BITS-1 -: K];
        partial = {{N_BITS{1'b0}}, a_q} * {{(2*N_BITS-K){1'b0}}, digit};
        acc_d   = (acc_q << K) + partial;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
`ifdef MUL_SIGNED_EN
            sign_q  <= 1'b0;
`endif
        end else if (clr_i) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
`ifdef MUL_SIGNED_EN
            sign_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.valid_i && ready_q) begin
`ifdef MUL_SIGNED_EN
                        // Magnitudes are stored unsigned so |most negative| still fits.
                        a_q    <= (bus.signed_i && bus.a_i[N_BITS-1]) ? -bus.a_i : bus.a_i;
                        b_q    <= (bus.signed_i && bus.b_i[N_BITS-1]) ? -bus.b_i : bus.b_i;
                        sign_q <= bus.signed_i && (bus.a_i[N_BITS-1] ^ bus.b_i[N_BITS-1]);
`else
                        a_q    <= bus.a_i;
                        b_q    <= bus.b_i;
`endif
                        acc_q   <= '0;
                        cnt_q   <= CW'(STEPS);
                        ready_q <= 1'b0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    acc_q <= acc_d;
                    b_q   <= b_q << K;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
`ifdef MUL_SIGNED_EN
                        acc_q <= sign_q ? -acc_d : acc_d;
`endif
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (bus.ready_i) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready_o  = ready_q;
    assign bus.valid_o  = valid_q;
    assign bus.res_lo_o = acc_q[N_BITS-1:0];
    assign bus.res_hi_o = acc_q[2*N_BITS-1:N_BITS];
endmodule

// File: tb/tb_r_mul_multicycle.sv
// Self-checking bench for r_mul_multicycle (N_BITS=32, N_RADIX=4).
// Expected products come from plain 64-bit arithmetic on the operands.
module tb_r_mul_multicycle;
    localparam int N   = 32;
    localparam int LAT = 16;
`ifdef MUL_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic clr;

    r_mul_multicycle_if #(.N_BITS(N)) mbus ();

    r_mul_multicycle #(.N_BITS(N), .N_RADIX(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (clr),
        .bus   (mbus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    function automatic logic [2*N-1:0] ref_product(input logic [N-1:0] a, input logic [N-1:0] b,
                                                   input logic s);
        logic signed [2*N-1:0] sa;
        logic signed [2*N-1:0] sb;
        logic signed [2*N-1:0] sp;
        if (s && SIGNED_EN) begin
            sa = {{N{a[N-1]}}, a};
            sb = {{N{b[N-1]}}, b};
            sp = sa * sb;
            return sp;
        end
        return {{N{1'b0}}, a} * {{N{1'b0}}, b};
    endfunction

    // Issues one operation at posedge+1, returns latency and the result seen,
    // holds ready_i low for 'hold' DONE cycles, and returns at posedge+1 after the handshake.
    task automatic do_mul(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                          input int hold, output int lat,
                          output logic [N-1:0] lo, output logic [N-1:0] hi);
        mbus.ready_i  = (hold == 0);
        mbus.a_i      = a;
        mbus.b_i      = b;
        mbus.signed_i = s;
        mbus.valid_i  = 1'b1;
        @(posedge clk); #1;
        mbus.valid_i  = 1'b0;
        mbus.a_i      = $urandom;
        mbus.b_i      = $urandom;
        lat = 0;
        while (mbus.valid_o !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        lo = mbus.res_lo_o;
        hi = mbus.res_hi_o;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
        end
        mbus.ready_i = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clr = 1'b0;
        mbus.valid_i  = 1'b0;
        mbus.ready_i  = 1'b1;
        mbus.a_i      = '0;
        mbus.b_i      = '0;
        mbus.signed_i = 1'b0;
        #12;
        vectors++; if (mbus.ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", mbus.ready_o); end
        vectors++; if (mbus.valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", mbus.valid_o); end
        vectors++; if (mbus.res_lo_o !== '0) begin miscompares++; $display("FAIL reset_lo: got %h expected 0", mbus.res_lo_o); end
        vectors++; if (mbus.res_hi_o !== '0) begin miscompares++; $display("FAIL reset_hi: got %h expected 0", mbus.res_hi_o); end
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat;
        logic [N-1:0] lo, hi;
        vectors++; if (mbus.ready_o !== 1'b1) begin miscompares++; $display("FAIL basic_ready_pre: got %b expected 1", mbus.ready_o); end
        do_mul(32'd7, 32'd6, 1'b0, 0, lat, lo, hi);
        vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL basic_latency: got %0d expected %0d", lat, LAT); end
        vectors++; if (lo !== 32'd42) begin miscompares++; $display("FAIL basic_lo: got %h expected %h", lo, 32'd42); end
        vectors++; if (hi !== 32'd0) begin miscompares++; $display("FAIL basic_hi: got %h expected 0", hi); end
        vectors++; if (mbus.ready_o !== 1'b1) begin miscompares++; $display("FAIL basic_ready_post: got %b expected 1", mbus.ready_o); end
        vectors++; if (mbus.valid_o !== 1'b0) begin miscompares++; $display("FAIL basic_valid_post: got %b expected 0", mbus.valid_o); end
    endtask

    task automatic test_max();
        int lat;
        logic [N-1:0] lo, hi;
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, lat, lo, hi);
        vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL max_latency: got %0d expected %0d", lat, LAT); end
        vectors++; if (lo !== 32'h0000_0001) begin miscompares++; $display("FAIL max_lo: got %h expected 00000001", lo); end
        vectors++; if (hi !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL max_hi: got %h expected fffffffe", hi); end
        do_mul(32'h1234_5678, 32'h0, 1'b0, 0, lat, lo, hi);
        vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL zero_latency: got %0d expected %0d", lat, LAT); end
        vectors++; if ({hi, lo} !== 64'h0) begin miscompares++; $display("FAIL zero_result: got %h%h expected 0", hi, lo); end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [N-1:0] lo0, hi0;
        logic [2*N-1:0] exp;
        exp = ref_product(32'hDEAD_BEEF, 32'h0001_2345, 1'b0);
        mbus.ready_i  = 1'b0;
        mbus.a_i      = 32'hDEAD_BEEF;
        mbus.b_i      = 32'h0001_2345;
        mbus.signed_i = 1'b0;
        mbus.valid_i  = 1'b1;
        @(posedge clk); #1;
        mbus.valid_i = 1'b0;
        lat = 0;
        while (mbus.valid_o !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL bp_latency: got %0d expected %0d", lat, LAT); end
        lo0 = mbus.res_lo_o;
        hi0 = mbus.res_hi_o;
        vectors++; if ({hi0, lo0} !== exp) begin miscompares++; $display("FAIL bp_result: got %h%h expected %h", hi0, lo0, exp); end
        // A new request arrives while the result is still pending.
        mbus.a_i     = 32'd9;
        mbus.b_i     = 32'd11;
        mbus.valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vectors++; if (mbus.valid_o !== 1'b1) begin miscompares++; $display("FAIL bp_valid_held[%0d]: got %b expected 1", i, mbus.valid_o); end
            vectors++; if (mbus.ready_o !== 1'b0) begin miscompares++; $display("FAIL bp_ready_low[%0d]: got %b expected 0", i, mbus.ready_o); end
            vectors++; if (mbus.res_lo_o !== lo0 || mbus.res_hi_o !== hi0) begin
                miscompares++; $display("FAIL bp_res_held[%0d]: got %h%h expected %h%h", i, mbus.res_hi_o, mbus.res_lo_o, hi0, lo0);
            end
        end
        mbus.ready_i = 1'b1;
        @(posedge clk); #1;
        vectors++; if (mbus.ready_o !== 1'b1) begin miscompares++; $display("FAIL bp_ready_after: got %b expected 1", mbus.ready_o); end
        vectors++; if (mbus.valid_o !== 1'b0) begin miscompares++; $display("FAIL bp_valid_after: got %b expected 0", mbus.valid_o); end
        @(posedge clk); #1;
        mbus.valid_i = 1'b0;
        vectors++; if (mbus.ready_o !== 1'b0) begin miscompares++; $display("FAIL bp_second_accept: got ready %b expected 0", mbus.ready_o); end
        lat = 0;
        while (mbus.valid_o !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL bp2_latency: got %0d expected %0d", lat, LAT); end
        vectors++; if ({mbus.res_hi_o, mbus.res_lo_o} !== 64'd99) begin
            miscompares++; $display("FAIL bp2_result: got %h%h expected 99", mbus.res_hi_o, mbus.res_lo_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_clear();
        int seen;
        mbus.ready_i  = 1'b1;
        mbus.a_i      = 32'h0000_1234;
        mbus.b_i      = 32'h0000_5678;
        mbus.signed_i = 1'b0;
        mbus.valid_i  = 1'b1;
        @(posedge clk); #1;
        mbus.valid_i = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        vectors++; if (mbus.ready_o !== 1'b1) begin miscompares++; $display("FAIL clr_ready: got %b expected 1", mbus.ready_o); end
        vectors++; if (mbus.valid_o !== 1'b0) begin miscompares++; $display("FAIL clr_valid: got %b expected 0", mbus.valid_o); end
        vectors++; if ({mbus.res_hi_o, mbus.res_lo_o} !== 64'h0) begin
            miscompares++; $display("FAIL clr_res: got %h%h expected 0", mbus.res_hi_o, mbus.res_lo_o);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (mbus.valid_o === 1'b1) seen++;
        end
        vectors++; if (seen !== 0) begin miscompares++; $display("FAIL clr_no_valid: got %0d valid cycles expected 0", seen); end
    endtask

    task automatic test_async_reset();
        int lat;
        logic [N-1:0] lo, hi;
        mbus.ready_i  = 1'b1;
        mbus.a_i      = 32'h0000_AAAA;
        mbus.b_i      = 32'h0000_5555;
        mbus.signed_i = 1'b0;
        mbus.valid_i  = 1'b1;
        @(posedge clk); #1;
        mbus.valid_i = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        vectors++; if (mbus.ready_o !== 1'b1) begin miscompares++; $display("FAIL arst_ready: got %b expected 1", mbus.ready_o); end
        vectors++; if (mbus.valid_o !== 1'b0) begin miscompares++; $display("FAIL arst_valid: got %b expected 0", mbus.valid_o); end
        vectors++; if ({mbus.res_hi_o, mbus.res_lo_o} !== 64'h0) begin
            miscompares++; $display("FAIL arst_res: got %h%h expected 0", mbus.res_hi_o, mbus.res_lo_o);
        end
        #2 rst = 1'b0;
        @(posedge clk); #1;
        do_mul(32'd3, 32'd5, 1'b0, 0, lat, lo, hi);
        vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL arst_op_latency: got %0d expected %0d", lat, LAT); end
        vectors++; if ({hi, lo} !== 64'd15) begin miscompares++; $display("FAIL arst_op_result: got %h%h expected 15", hi, lo); end
    endtask

    task automatic test_signed();
        int lat;
        logic [N-1:0] lo, hi;
        logic [N-1:0] exp_hi;
        exp_hi = SIGNED_EN ? 32'hFFFF_FFFF : 32'h0000_0004;
        do_mul(32'hFFFF_FFFD, 32'd5, 1'b1, 0, lat, lo, hi);
        vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL signed_latency: got %0d expected %0d", lat, LAT); end
        vectors++; if (lo !== 32'hFFFF_FFF1) begin miscompares++; $display("FAIL signed_lo: got %h expected fffffff1", lo); end
        vectors++; if (hi !== exp_hi) begin miscompares++; $display("FAIL signed_hi: got %h expected %h", hi, exp_hi); end
        do_mul(32'h8000_0000, 32'h8000_0000, 1'b1, 1, lat, lo, hi);
        vectors++; if (hi !== 32'h4000_0000 || lo !== 32'h0) begin
            miscompares++; $display("FAIL signed_minmin: got %h%h expected 4000000000000000", hi, lo);
        end
    endtask

    task automatic test_random();
        int lat;
        int sel;
        logic [N-1:0] a, b, lo, hi;
        logic s;
        logic [2*N-1:0] exp;
        for (int i = 0; i < 30; i++) begin
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 5);
            if (sel == 0) a = '0;
            if (sel == 1) b = '1;
            if (sel == 2) a = 32'h8000_0000;
            s   = 1'($urandom_range(0, 1));
            exp = ref_product(a, b, s);
            do_mul(a, b, s, $urandom_range(0, 3), lat, lo, hi);
            vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, LAT); end
            vectors++; if ({hi, lo} !== exp) begin
                miscompares++; $display("FAIL rand_result[%0d]: a=%h b=%h s=%b got %h%h expected %h", i, a, b, s, hi, lo, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_backpressure();
        test_clear();
        test_async_reset();
        test_signed();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/r_mul_multicycle.md
Name: r_mul_multicycle

Overview:
- Multicycle radix-N_RADIX shift-add multiplier. Companion and inverse of the restoring divider stage chain in the PE div FU.
- Each cycle consumes log2(N_RADIX) multiplier bits, MSB-first, and accumulates `acc = (acc << K) + a*digit`. This is the mirror of the divider's shift-subtract recurrence.
- Sits in the PE FU alongside the divider. Uses the same valid/ready operand and result handshake.

Parameters:
- N_BITS, 32, operand width. Must be divisible by K = $clog2(N_RADIX).
- N_RADIX, 4, digit radix. Power of two, ≥2. K = $clog2(N_RADIX) bits are consumed per cycle.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- clr_i  in  1  synchronous abort; returns the block to IDLE
- valid_i  in  1  operands valid
- ready_o  out  1  block can accept operands
- a_i  in  N_BITS  multiplicand
- b_i  in  N_BITS  multiplier
- signed_i  in  1  signed operation request; ignored unless MUL_SIGNED_EN is defined
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts result
- res_lo_o  out  N_BITS  product bits [N_BITS-1:0]
- res_hi_o  out  N_BITS  product bits [2*N_BITS-1:N_BITS]

Behaviour:
- States: IDLE, BUSY, DONE. Registers:
  - a_q (N_BITS)
  - b_q (N_BITS) shift register
  - acc_q (2*N_BITS)
  - cnt_q ($clog2(N_BITS/K+1) bits)
- Reset (async, rst_i=1):
  - state=IDLE, all registers 0.
  - ready_o=1, valid_o=0, res_lo_o=0, res_hi_o=0.
- IDLE:
  - ready_o=1.
  - On valid_i&&ready_o: a_q=a_i, b_q=b_i, acc_q=0, cnt_q=N_BITS/K, state→BUSY.
- BUSY:
  - ready_o=0, valid_o=0.
  - Each edge: digit = b_q[N_BITS-1 -: K].
  - acc_q = (acc_q << K) + zero-extended a_q*digit, computed in 2*N_BITS width. Bits shifted out are discarded; no overflow is possible.
  - b_q <<= K; cnt_q -= 1.
  - On the edge where cnt_q==1: state→DONE.
- Latency: valid_o is high exactly N_BITS/K cycles after the accept edge (16 for defaults).
- DONE:
  - valid_o=1, ready_o=0.
  - res_hi_o/res_lo_o = acc_q halves, held stable while valid_o&&!ready_i.
  - On valid_o&&ready_i: state→IDLE; ready_o=1 the next cycle.
  - No accept occurs in the same cycle as the result handshake.
- Outputs res_* are driven from acc_q in every state.
  - In IDLE they show the last result, or 0 after reset.
  - In BUSY they are don't-care and must not be sampled.
- clr_i: has priority over everything except rst_i. From any state →IDLE next edge; acc_q, b_q, cnt_q cleared; any in-flight or unconsumed result is dropped.
- Zero operands: no early termination; always N_BITS/K cycles.
- valid_i while BUSY/DONE: ignored. The producer must hold it until ready_o.

Optional Feature:
- Macro: MUL_SIGNED_EN.
- Defined:
  - On accept with signed_i=1, a_q/b_q load |a_i|/|b_i| (two's complement). A sign_q flag registers a_i[MSB]^b_i[MSB].
  - On the BUSY→DONE edge, acc_q is replaced by its 2*N_BITS two's-complement negation if sign_q=1.
  - The magnitude of the most negative value fits because it is stored unsigned. Latency is unchanged.
- Not defined: signed_i is ignored; the operation is always unsigned; there is no sign_q register or negation logic.

Test Plan (N_BITS=32, N_RADIX=4):
- Basic: a=7, b=6, ready_i=1 → valid_o rises 16 cycles after the accept edge; res_lo=42, res_hi=0; ready_o=1 the cycle after the result handshake.
- Max unsigned: a=b=0xFFFFFFFF → res_lo=0x00000001, res_hi=0xFFFFFFFE. Also a=0x12345678, b=0 → 0/0 after 16 cycles.
- Backpressure: ready_i=0 for 5 cycles after valid_o → valid_o and res_* held constant and ready_o=0 throughout; ready_i=1 → IDLE next edge. A new valid_i applied during DONE is not accepted until ready_o=1.
- Abort/reset: assert clr_i at BUSY cycle 8 → IDLE next edge, valid_o never rises, res_*=0. Assert rst_i asynchronously mid-BUSY → immediate ready_o=1, valid_o=0, res_*=0. Then 3*5 completes → 15.
- Signed (MUL_SIGNED_EN defined): signed_i=1, a=0xFFFFFFFD (-3), b=5 → res_lo=0xFFFFFFF1, res_hi=0xFFFFFFFF. Also a=b=0x80000000 → res_hi=0x40000000, res_lo=0.
- Signed (MUL_SIGNED_EN not defined): the same -3*5 stimulus with signed_i=1 → unsigned result res_lo=0xFFFFFFF1, res_hi=0x00000004.
